// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a UART frame serializer.
// Define UART_TX_SCHEDULER_PARITY_EN to add an even-parity bit.
module uart_tx_scheduler #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_tick,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
`ifdef UART_TX_SCHEDULER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] data;
  logic              stop_cnt;
  logic              stop_last;

  logic [N_REQ-1:0]  pick;
  logic [ID_W-1:0]   pick_id;
  logic              found;
  logic              take;
  int                idx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = ID_W'(idx);
      end
    end
  end

  assign take      = found && (state == S_IDLE) && rst;
  assign req_ready = take ? pick : '0;
  assign stop_last = (STOP_BITS == 1) || stop_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      bit_cnt  <= '0;
      data     <= '0;
      stop_cnt <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            data     <= req_data[int'(pick_id)*DATA_W +: DATA_W];
            grant_id <= pick_id;
            rr_ptr   <= (pick_id == LAST_ID) ? '0
                                            : pick_id + ID_W'(1);
            busy     <= 1'b1;
            state    <= S_ALIGN;
          end
        end
        // Coincident ticks at accept are skipped so start is a full bit.
        S_ALIGN: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx      <= data[0];
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_SCHEDULER_PARITY_EN
              tx    <= ^data;
              state <= S_PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx      <= data[bit_cnt + CNT_W'(1)];
            end
          end
        end
`ifdef UART_TX_SCHEDULER_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            if (stop_last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a frame scoreboard.
// Honours UART_TX_SCHEDULER_PARITY_EN for frame length and parity.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int BIT = 16;
`ifdef UART_TX_SCHEDULER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic           clk;
  logic           rst;
  logic           baud_tick;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [1:0]     grant_id;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   tick_en  = 1'b1;
  int   tick_cnt = 0;
  int   n;
  logic [1:0] ids [5];

  uart_tx_scheduler #(
    .N_REQ(N), .DATA_W(W), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy),
    .grant_id(grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick_cnt  = (tick_cnt == BIT - 1) ? 0 : tick_cnt + 1;
      baud_tick = tick_en && (tick_cnt == BIT - 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[i*W +: W] = b;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int k = 0;
    while (busy !== lvl && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic recv_frame(input string tag);
    exp_t       e;
    logic [7:0] got;
    int         k;
    got = '0;
    check({tag, " sb"}, (sb.size() > 0), 1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{data: 8'h00, id: 2'd0};
    k = 0;
    while (tx !== 1'b0 && k < 800) begin
      @(negedge clk);
      k++;
    end
    check({tag, " start"}, tx, 0);
    if (tx !== 1'b0) return;
    repeat (BIT / 2) @(negedge clk);
    check({tag, " start_mid"}, tx, 0);
    for (int i = 0; i < W; i++) begin
      repeat (BIT) @(negedge clk);
      got[i] = tx;
      if (i == 3) begin
        check({tag, " ready_mid"}, req_ready, 0);
        check({tag, " grant_id"}, grant_id, e.id);
      end
    end
`ifdef UART_TX_SCHEDULER_PARITY_EN
    repeat (BIT) @(negedge clk);
    check({tag, " parity"}, tx, ^e.data);
`endif
    repeat (BIT) @(negedge clk);
    check({tag, " stop"}, tx, 1);
    check({tag, " data"}, got, e.data);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_gid", grant_id, 0);
    rst = 1'b1;
    @(negedge clk);

    // 0x55 from requester 0
    set_byte(0, 8'h55);
    req_valid = 4'b0001;
    sb.push_back('{data: 8'h55, id: 2'd0});
    #1 check("r028_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("r028_busy", busy, 1);
    recv_frame("r028");
    repeat (BIT / 2 + 1) @(negedge clk);
    check("r028_busy_end", busy, 0);

    // 0x07: parity bit, then frame length
    set_byte(1, 8'h07);
    req_valid = 4'b0010;
    sb.push_back('{data: 8'h07, id: 2'd1});
    @(negedge clk);
    req_valid = '0;
    recv_frame("r030");
    wait_busy(1'b0, "r030_idle");
    set_byte(2, 8'h07);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (tx !== 1'b0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy !== 1'b0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("r030_len", n, BIT * FRAME_BITS);

    // request coinciding with a tick
    set_byte(2, 8'h33);
    n = 0;
    while (baud_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    check("r032_busy", busy, 1);
    check("r032_gid", grant_id, 2);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("r032_align", n, BIT);
    n = 0;
    while (tx !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("r032_start", n, BIT);
    wait_busy(1'b0, "r032_idle");

    // no ticks: FSM must hold
    tick_en = 1'b0;
    set_byte(3, 8'hC3);
    req_valid = 4'b1000;
    sb.push_back('{data: 8'hC3, id: 2'd3});
    @(negedge clk);
    req_valid = '0;
    repeat (40) @(negedge clk);
    check("r022_busy", busy, 1);
    check("r022_tx", tx, 1);
    tick_en = 1'b1;
    recv_frame("r022");

    // all four requesters
    for (int i = 0; i < N; i++) set_byte(i, 8'hA0 + 8'(i));
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int f = 0; f < 5; f++)
      sb.push_back('{data: 8'hA0 + 8'(ids[f]), id: ids[f]});
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_busy(1'b0, "r029_idle");
      #1 check("r029_ready", req_ready, 4'b0001 << ids[f]);
      if (f == 4) begin
        @(negedge clk);
        req_valid = '0;
      end
      recv_frame("r029");
    end
    wait_busy(1'b0, "r029_done");
    repeat (20) @(negedge clk);
    check("r029_quiet", busy, 0);

    // requester 1 changes data and valid mid-frame
    set_byte(1, 8'h3C);
    req_valid = 4'b0010;
    sb.push_back('{data: 8'h3C, id: 2'd1});
    @(negedge clk);
    set_byte(1, 8'hFF);
    check("r033_ready", req_ready, 0);
    recv_frame("r033");
    req_valid = '0;
    wait_busy(1'b0, "r033_idle");
    repeat (20) @(negedge clk);
    check("r033_quiet", busy, 0);

    // reset during data bit 3
    set_byte(2, 8'h5A);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (tx !== 1'b0 && n < 800) begin
      @(negedge clk);
      n++;
    end
    repeat (BIT / 2 + 4 * BIT) @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("r031_tx", tx, 1);
    check("r031_busy", busy, 0);
    check("r031_ready", req_ready, 0);
    rst = 1'b1;
    #1 check("r031_regrant", req_ready, 4'b0001);
    sb.push_back('{data: 8'hA0, id: 2'd0});
    @(negedge clk);
    req_valid = '0;
    check("r031_gid", grant_id, 0);
    recv_frame("r031");
    wait_busy(1'b0, "r031_idle");
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
